// File: rtl/ahb_bus_arbiter.sv
// ----------------------------------------------------------------------------
// ahb_bus_arbiter
// Round-robin arbiter for one shared AHB slave path. It produces a one-hot
// address-phase grant and keeps ownership locked for fixed-length bursts
// and, up to a hold limit, for undefined-length INCR bursts. It also tracks
// the data-phase owner so the mux can steer write data and responses.
//
// Optional build macro: AHB_ARB_LOCK_EN (adds HMASTLOCK-style locking).
//
// Ports:
//   ahb_clk_in            in   bus clock, rising edge
//   ahb_rst_in            in   synchronous reset, active-high
//   ahb_req_in            in   per-master bus request
//   ahb_lock_in           in   per-master lock (AHB_ARB_LOCK_EN only)
//   ahb_trans_in          in   HTRANS of the currently granted master
//   ahb_burst_in          in   HBURST of the currently granted master
//   ahb_ready_in          in   HREADY from the shared slave path
//   ahb_grant_out         out  one-hot address-phase grant
//   ahb_master_out        out  index of address-phase owner (mux select)
//   ahb_master_data_out   out  index of data-phase owner
//   ahb_burst_active_out  out  high while a burst is locked to the owner
//
// State     | meaning
// ARB_IDLE  | owner may start a new transfer; grant can move
// ARB_BURST | fixed-length burst in flight; grant frozen until last beat
// ARB_INCR  | undefined-length INCR burst; grant moves on IDLE/NONSEQ or
//           | once the hold limit is reached while others are requesting
// ----------------------------------------------------------------------------
module ahb_bus_arbiter #(
    parameter int AHB_MASTER_NUM   = 4,
    parameter int AHB_MASTER_WIDTH = $clog2(AHB_MASTER_NUM),
    parameter int AHB_MAX_HOLD     = 16
) (
    input  logic                        ahb_clk_in,
    input  logic                        ahb_rst_in,
    input  logic [AHB_MASTER_NUM-1:0]   ahb_req_in,
`ifdef AHB_ARB_LOCK_EN
    input  logic [AHB_MASTER_NUM-1:0]   ahb_lock_in,
`endif
    input  logic [1:0]                  ahb_trans_in,
    input  logic [2:0]                  ahb_burst_in,
    input  logic                        ahb_ready_in,
    output logic [AHB_MASTER_NUM-1:0]   ahb_grant_out,
    output logic [AHB_MASTER_WIDTH-1:0] ahb_master_out,
    output logic [AHB_MASTER_WIDTH-1:0] ahb_master_data_out,
    output logic                        ahb_burst_active_out
);

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_BURST = 2'd1,
        ARB_INCR  = 2'd2
    } arb_state_t;

    localparam logic [1:0] TRANS_IDLE   = 2'd0;
    localparam logic [1:0] TRANS_NONSEQ = 2'd2;
    localparam logic [1:0] TRANS_SEQ    = 2'd3;

    arb_state_t                  r_state;
    logic [AHB_MASTER_NUM-1:0]   r_grant;
    logic [AHB_MASTER_WIDTH-1:0] r_master;
    logic [AHB_MASTER_WIDTH-1:0] r_master_data;
    logic [AHB_MASTER_WIDTH-1:0] r_rr_ptr;
    logic                        r_burst_active;
    logic [3:0]                  r_beat_cnt;
    logic [7:0]                  r_hold_cnt;

    arb_state_t                  w_state_nxt;
    logic [3:0]                  w_beat_nxt;
    logic [7:0]                  w_hold_nxt;
    logic                        w_rearb;
    logic                        w_start;
    logic                        w_suppress;
    logic                        w_others_req;
    logic                        w_hold_full;
    logic [AHB_MASTER_WIDTH-1:0] w_winner;
    logic [AHB_MASTER_NUM-1:0]   w_winner_onehot;

    // Round-robin search starting just after the pointer. Scanning from the
    // farthest candidate down to the nearest lets the nearest requester win
    // without a separate found flag; no requester leaves master 0.
    function automatic logic [AHB_MASTER_WIDTH-1:0] f_pick(
        input logic [AHB_MASTER_NUM-1:0]   req,
        input logic [AHB_MASTER_WIDTH-1:0] ptr
    );
        logic [AHB_MASTER_WIDTH-1:0] win;
        int                          idx;
        win = '0;
        for (int k = AHB_MASTER_NUM; k >= 1; k--) begin
            idx = (int'(ptr) + k) % AHB_MASTER_NUM;
            if (req[idx]) win = idx[AHB_MASTER_WIDTH-1:0];
        end
        return win;
    endfunction

`ifdef AHB_ARB_LOCK_EN
    // Remembers that the owner held the bus locked; re-arbitration stays
    // suppressed until the owner shows an IDLE after releasing the lock.
    logic r_lock_seen;
    logic w_owner_lock;
    assign w_owner_lock = |(ahb_lock_in & r_grant);
    assign w_suppress   = w_owner_lock | (r_lock_seen & (ahb_trans_in != TRANS_IDLE));

    always_ff @(posedge ahb_clk_in) begin
        if (ahb_rst_in) begin
            r_lock_seen <= 1'b0;
        end else if (ahb_ready_in) begin
            r_lock_seen <= w_owner_lock | (r_lock_seen & (ahb_trans_in != TRANS_IDLE));
        end
    end
`else
    assign w_suppress = 1'b0;
`endif

    assign w_winner        = f_pick(ahb_req_in, r_rr_ptr);
    assign w_winner_onehot = {{(AHB_MASTER_NUM-1){1'b0}}, 1'b1} << w_winner;
    assign w_others_req    = |(ahb_req_in & ~r_grant);
    assign w_hold_full     = (r_hold_cnt == 8'(AHB_MAX_HOLD));

    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat_cnt;
        w_hold_nxt  = r_hold_cnt;
        w_rearb     = 1'b0;
        w_start     = 1'b0;

        case (r_state)
            ARB_IDLE: begin
                if (ahb_trans_in == TRANS_IDLE) begin
                    w_rearb = 1'b1;
                end else if (ahb_trans_in == TRANS_NONSEQ) begin
                    w_start = 1'b1;
                end
            end
            ARB_BURST: begin
                if (ahb_trans_in == TRANS_SEQ) begin
                    w_beat_nxt = r_beat_cnt - 4'd1;
                    if (r_beat_cnt == 4'd1) begin
                        w_rearb     = 1'b1;
                        w_state_nxt = ARB_IDLE;
                    end
                end else if (ahb_trans_in == TRANS_IDLE) begin
                    // Early termination (e.g. after an ERROR response).
                    w_rearb     = 1'b1;
                    w_beat_nxt  = 4'd0;
                    w_state_nxt = ARB_IDLE;
                end else if (ahb_trans_in == TRANS_NONSEQ) begin
                    // New transfer from the owner: treat it as a fresh start.
                    w_beat_nxt  = 4'd0;
                    w_state_nxt = ARB_IDLE;
                    w_start     = 1'b1;
                end
            end
            ARB_INCR: begin
                if (w_hold_full && w_others_req && !w_suppress) begin
                    w_rearb     = 1'b1;
                    w_hold_nxt  = 8'd0;
                    w_state_nxt = ARB_IDLE;
                end else if (ahb_trans_in == TRANS_SEQ) begin
                    if (!w_hold_full) w_hold_nxt = r_hold_cnt + 8'd1;
                end else if ((ahb_trans_in == TRANS_IDLE) || (ahb_trans_in == TRANS_NONSEQ)) begin
                    w_rearb     = 1'b1;
                    w_hold_nxt  = 8'd0;
                    w_state_nxt = ARB_IDLE;
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase

        if (w_start) begin
            case (ahb_burst_in)
                3'd0: begin
                    w_rearb = 1'b1;
                end
                3'd1: begin
                    w_hold_nxt  = 8'd1;
                    w_state_nxt = ARB_INCR;
                end
                3'd2, 3'd3: begin
                    w_beat_nxt  = 4'd3;
                    w_state_nxt = ARB_BURST;
                end
                3'd4, 3'd5: begin
                    w_beat_nxt  = 4'd7;
                    w_state_nxt = ARB_BURST;
                end
                default: begin
                    w_beat_nxt  = 4'd15;
                    w_state_nxt = ARB_BURST;
                end
            endcase
        end

        if (w_suppress) w_rearb = 1'b0;
    end

    always_ff @(posedge ahb_clk_in) begin
        if (ahb_rst_in) begin
            r_state        <= ARB_IDLE;
            r_grant        <= {{(AHB_MASTER_NUM-1){1'b0}}, 1'b1};
            r_master       <= '0;
            r_master_data  <= '0;
            r_rr_ptr       <= '0;
            r_burst_active <= 1'b0;
            r_beat_cnt     <= 4'd0;
            r_hold_cnt     <= 8'd0;
        end else if (ahb_ready_in) begin
            r_state        <= w_state_nxt;
            r_beat_cnt     <= w_beat_nxt;
            r_hold_cnt     <= w_hold_nxt;
            r_master_data  <= r_master;
            r_burst_active <= (w_state_nxt != ARB_IDLE);
            if (w_rearb) begin
                r_grant  <= w_winner_onehot;
                r_master <= w_winner;
                // The pointer only advances when someone actually won.
                if (|ahb_req_in) r_rr_ptr <= w_winner;
            end
        end
    end

    assign ahb_grant_out        = r_grant;
    assign ahb_master_out       = r_master;
    assign ahb_master_data_out  = r_master_data;
    assign ahb_burst_active_out = r_burst_active;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
module tb_ahb_bus_arbiter;

    localparam int N    = 4;
    localparam int W    = 2;
    localparam int HOLD = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic [1:0]   trans;
    logic [2:0]   burst;
    logic         ready;
    logic [N-1:0] grant;
    logic [W-1:0] master;
    logic [W-1:0] master_data;
    logic         burst_active;

    always #5 clk = ~clk;

    ahb_bus_arbiter #(
        .AHB_MASTER_NUM (N),
        .AHB_MAX_HOLD   (HOLD)
    ) dut (
        .ahb_clk_in           (clk),
        .ahb_rst_in           (rst),
        .ahb_req_in           (req),
`ifdef AHB_ARB_LOCK_EN
        .ahb_lock_in          ('0),
`endif
        .ahb_trans_in         (trans),
        .ahb_burst_in         (burst),
        .ahb_ready_in         (ready),
        .ahb_grant_out        (grant),
        .ahb_master_out       (master),
        .ahb_master_data_out  (master_data),
        .ahb_burst_active_out (burst_active)
    );

    typedef struct packed {
        logic [N-1:0] grant;
        logic [W-1:0] master;
        logic [W-1:0] data;
        logic         active;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: who owns the bus, who owned it one transfer ago,
    // where the round-robin search resumes, and how much of the current
    // burst remains (fixed) or has been used (INCR).
    int m_owner, m_data, m_rr;
    int m_left;       // beats still owed in a fixed burst, 0 = none
    int m_incr;       // beats accepted so far in an INCR burst, 0 = none

    function automatic int pick(input logic [N-1:0] r);
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (m_rr + k) % N;
            if (r[idx]) return idx;
        end
        return 0;
    endfunction

    task automatic model_step(input logic r_st, input logic [N-1:0] r_q,
                              input logic [1:0] tr, input logic [2:0] bu,
                              input logic rd);
        bit move, start;
        int prev;
        if (r_st) begin
            m_owner = 0; m_data = 0; m_rr = 0; m_left = 0; m_incr = 0;
        end else if (rd) begin
            move  = 0;
            start = 0;
            prev  = m_owner;
            if (m_left > 0) begin
                if (tr == 3) begin
                    m_left = m_left - 1;
                    if (m_left == 0) move = 1;
                end else if (tr == 0) begin
                    m_left = 0; move = 1;
                end else if (tr == 2) begin
                    m_left = 0; start = 1;
                end
            end else if (m_incr > 0) begin
                if (m_incr == HOLD && (r_q & ~(4'(1) << m_owner)) != 0) begin
                    m_incr = 0; move = 1;
                end else if (tr == 3) begin
                    if (m_incr < HOLD) m_incr = m_incr + 1;
                end else if (tr == 0 || tr == 2) begin
                    m_incr = 0; move = 1;
                end
            end else begin
                if (tr == 0) move = 1;
                else if (tr == 2) start = 1;
            end
            if (start) begin
                if (bu == 0) move = 1;
                else if (bu == 1) m_incr = 1;
                else m_left = (4 << ((int'(bu) - 2) / 2)) - 1;
            end
            if (move) begin
                if (r_q != 0) begin
                    m_owner = pick(r_q);
                    m_rr    = m_owner;
                end else begin
                    m_owner = 0;
                end
            end
            m_data = prev;
        end
    endtask

    task automatic cyc(input logic r_st, input logic [N-1:0] r_q,
                       input logic [1:0] tr, input logic [2:0] bu, input logic rd);
        exp_t e;
        @(negedge clk);
        rst = r_st; req = r_q; trans = tr; burst = bu; ready = rd;
        model_step(r_st, r_q, tr, bu, rd);
        e.grant  = N'(1) << m_owner;
        e.master = W'(m_owner);
        e.data   = W'(m_data);
        e.active = (m_left > 0) || (m_incr > 0);
        q.push_back(e);
    endtask

    task automatic chk(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, want);
        end
    endtask

    // Monitor: every clock edge with a pending expectation is compared.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("grant",        int'(grant),        int'(e.grant));
                chk("master_out",   int'(master),       int'(e.master));
                chk("master_data",  int'(master_data),  int'(e.data));
                chk("burst_active", int'(burst_active), int'(e.active));
                chk("grant_onehot", int'($onehot(grant)), 1);
            end
        end
    end

    initial begin
        int r;
        logic [1:0] tr;
        logic [2:0] bu;
        rst = 1'b1; req = '0; trans = 2'd0; burst = 3'd0; ready = 1'b1;
        m_owner = 0; m_data = 0; m_rr = 0; m_left = 0; m_incr = 0;

        // Reset, then idle with no requests: master 0 stays default.
        repeat (2) cyc(1, 4'b0000, 0, 0, 1);
        repeat (3) cyc(0, 4'b0000, 0, 0, 1);

        // Round-robin alternation between masters 1 and 2.
        cyc(1, 4'b0000, 0, 0, 1);
        cyc(0, 4'b0110, 0, 0, 1);
        cyc(0, 4'b0110, 2, 0, 1);
        cyc(0, 4'b0110, 2, 0, 1);

        // Master 1 INCR4 with wait states on beat 2.
        cyc(0, 4'b1111, 2, 3, 1);
        cyc(0, 4'b1111, 3, 3, 1);
        cyc(0, 4'b1111, 3, 3, 0);
        cyc(0, 4'b1111, 3, 3, 0);
        cyc(0, 4'b1111, 3, 3, 1);
        cyc(0, 4'b1111, 3, 3, 1);
        cyc(0, 4'b1111, 0, 0, 1);

        // INCR hold limit with a competitor, then alone.
        cyc(1, 4'b0000, 0, 0, 1);
        cyc(0, 4'b0011, 2, 1, 1);
        repeat (4) cyc(0, 4'b0011, 3, 1, 1);
        cyc(0, 4'b0011, 0, 0, 1);
        cyc(1, 4'b0000, 0, 0, 1);
        cyc(0, 4'b0001, 2, 1, 1);
        repeat (6) cyc(0, 4'b0001, 3, 1, 1);
        cyc(0, 4'b0001, 0, 0, 1);

        // WRAP8 with BUSY after the third beat.
        cyc(1, 4'b0000, 0, 0, 1);
        cyc(0, 4'b0011, 2, 4, 1);
        repeat (2) cyc(0, 4'b0011, 3, 4, 1);
        cyc(0, 4'b0011, 1, 4, 1);
        repeat (5) cyc(0, 4'b0011, 3, 4, 1);
        cyc(0, 4'b0011, 0, 0, 1);

        // Reset in the middle of INCR16.
        cyc(1, 4'b0000, 0, 0, 1);
        cyc(0, 4'b0110, 2, 7, 1);
        cyc(0, 4'b0110, 3, 7, 1);
        cyc(1, 4'b0110, 3, 7, 1);
        cyc(0, 4'b0000, 0, 0, 1);

        // Randomized traffic with legal-looking HTRANS per burst phase.
        for (int i = 0; i < 600; i++) begin
            r  = int'($urandom_range(0, 99));
            bu = 3'($urandom_range(0, 7));
            if (m_left > 0)
                tr = (r < 70) ? 2'd3 : (r < 85) ? 2'd1 : (r < 95) ? 2'd0 : 2'd2;
            else if (m_incr > 0)
                tr = (r < 60) ? 2'd3 : (r < 75) ? 2'd1 : (r < 90) ? 2'd0 : 2'd2;
            else
                tr = (r < 40) ? 2'd0 : 2'd2;
            cyc(($urandom_range(0, 99) == 0), N'($urandom_range(0, 15)), tr, bu,
                ($urandom_range(0, 3) != 0));
        end

        @(negedge clk);
        ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ahb_bus_arbiter.md
Name: ahb_bus_arbiter

Overview:
- Round-robin arbiter that shares one AHB slave path (address/control/wdata mux feeding ahb_slave_if) among AHB_MASTER_NUM masters.
- Issues a one-hot address-phase grant and tracks fixed-length bursts so ownership changes only at legal burst boundaries.
- Also tracks the data-phase owner so the mux can steer write data and route HREADY/HRESP back to the right master.
- Sits between the master request lines and the shared-bus mux, one per AHB layer.

Parameters:
- AHB_MASTER_NUM, 4, number of requesting masters (2..8).
- AHB_MASTER_WIDTH, $clog2(AHB_MASTER_NUM), width of master index outputs.
- AHB_MAX_HOLD, 16, max accepted beats of an undefined-length INCR burst before forced re-arbitration when others request (1..255).

Ports:
- ahb_clk_in  input  1  bus clock, all logic on rising edge.
- ahb_rst_in  input  1  synchronous reset, active-high.
- ahb_req_in  input  AHB_MASTER_NUM  per-master bus request.
- ahb_trans_in  input  2  HTRANS of the muxed (currently granted) master.
- ahb_burst_in  input  3  HBURST of the muxed master.
- ahb_ready_in  input  1  HREADY from the shared slave path.
- ahb_grant_out  output  AHB_MASTER_NUM  one-hot address-phase grant.
- ahb_master_out  output  AHB_MASTER_WIDTH  index of address-phase owner (mux select).
- ahb_master_data_out  output  AHB_MASTER_WIDTH  index of data-phase owner.
- ahb_burst_active_out  output  1  high while a burst is locked to the current owner.

Behaviour:
- Reset (ahb_rst_in=1 at clock edge): grant=0001 (master 0 default), ahb_master_out=0, ahb_master_data_out=0, ahb_burst_active_out=0, rr pointer=0, beat counter=0, hold counter=0, state ARB_IDLE. Reset mid-burst aborts tracking immediately; no completion.
- Trans codes: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3. Burst codes: SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7.
- "Beat accepted" = ahb_ready_in=1 and trans is NONSEQ or SEQ.
- Registered outputs update only on edges where ahb_ready_in=1; with ready low every output and counter holds.
- ahb_master_data_out <= ahb_master_out on every ready-high edge (one-transfer pipeline offset).
- Arbitration: search from rr pointer+1 upward modulo AHB_MASTER_NUM; first requester wins. rr pointer <= winner on grant change. No requester -> grant master 0 (default master). Re-granting the same master is allowed.
- States:
  - ARB_IDLE: owner may start. Accepted NONSEQ with SINGLE -> re-arbitrate same edge, stay ARB_IDLE. Accepted NONSEQ fixed burst -> beat counter <= beats-1 (3/7/15), ARB_BURST. Accepted NONSEQ INCR -> hold counter <= 1, ARB_INCR. IDLE with ready -> re-arbitrate.
  - ARB_BURST: ahb_burst_active_out=1; grant frozen. Accepted SEQ decrements counter; BUSY holds. Counter reaching 0 on an accepted SEQ -> re-arbitrate same edge, ARB_IDLE. IDLE or NONSEQ while counter!=0 (early termination after ERROR) -> re-arbitrate, ARB_IDLE; a NONSEQ there is handled as in ARB_IDLE on the same edge.
  - ARB_INCR: ahb_burst_active_out=1. Accepted SEQ increments hold counter (saturating at AHB_MAX_HOLD). IDLE or NONSEQ -> re-arbitrate, ARB_IDLE. Hold counter==AHB_MAX_HOLD and another master requesting -> re-arbitrate on next ready-high edge, ARB_IDLE (master restarts with NONSEQ later).
- Grant outputs never change while ahb_ready_in=0; grant is always exactly one-hot.
- Owner dropping ahb_req_in mid fixed burst is ignored until burst end.
- Simultaneous burst end and new requests: new winner granted on that same edge, no dead cycle.

Optional Feature:
- AHB_ARB_LOCK_EN: adds port ahb_lock_in input AHB_MASTER_NUM (HMASTLOCK per master). While the owner's lock bit is high, re-arbitration is suppressed in all states (including AHB_MAX_HOLD expiry); it resumes on the first ready-high edge after the lock bit drops with trans IDLE. Without the macro: port absent, no locking behaviour.

Test Plan:
- Reset, req=0000 -> grant=0001, master_out=0, burst_active=0; after 3 idle cycles unchanged.
- req=0110 after reset, SINGLE NONSEQs, ready=1 -> grant 0010, then 0100, then 0010 (round-robin alternation).
- Master1 INCR4 (NONSEQ+3 SEQ) with req=1111, ready low 2 cycles on beat 2 -> grant stays 0010 until 4th beat accepted, then 0100; master_data_out lags master_out by one ready edge.
- Master0 INCR with AHB_MAX_HOLD=4, req=0011 -> after 4 accepted beats grant moves to 0010; with req=0001 only, master0 keeps grant past 4 beats.
- WRAP8 with BUSY inserted at beat 3 -> counter held during BUSY, release after 8th accepted beat, not 7th.
- Reset asserted at beat 2 of INCR16 -> next edge grant=0001, burst_active=0, counters 0.
